// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - gray/binary helpers and shared constants for the async FIFO
package async_fifo_pkg;

    localparam int MIN_SYNC_STAGES = 2;

    // Helpers work on a 32-bit carrier; width selects how many low bits are meaningful.
    function automatic logic [31:0] width_mask(input int width);
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return mask;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin, input int width);
        return (bin ^ (bin >> 1)) & width_mask(width);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int width);
        logic [31:0] g;
        logic [31:0] b;
        g = gray & width_mask(width);
        b = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/cdc_sync_bus.sv
// rtl/cdc_sync_bus.sv - multi-flop synchroniser for a gray-coded bus
module cdc_sync_bus #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_lvl.sv
// rtl/async_fifo_lvl.sv - dual-clock FIFO with fill levels, almost flags and sticky errors
module async_fifo_lvl
    import async_fifo_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int DW          = 32,
    parameter int SYNC_STAGES = 2,
    parameter int AF_MARGIN   = 2,
    parameter int AE_MARGIN   = 2
) (
    input  logic                      wrClk,
    input  logic                      wrRst_n,
    input  logic                      rdClk,
    input  logic                      rdRst_n,
    input  logic                      wrEn,
    input  logic [DW-1:0]             wrData,
    output logic                      full,
    output logic                      almostFull,
    output logic [$clog2(DEPTH):0]    wrCount,
    output logic                      overflow,
    input  logic                      rdEn,
    output logic [DW-1:0]             rdData,
    output logic                      rdValid,
    output logic                      empty,
    output logic                      almostEmpty,
    output logic [$clog2(DEPTH):0]    rdCount,
    output logic                      underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "async_fifo_lvl: DEPTH must be a power of 2 and at least 4");
    end
    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
        $fatal(1, "async_fifo_lvl: SYNC_STAGES too small");
    end
    if (AF_MARGIN < 1 || AF_MARGIN > DEPTH - 1) begin : g_bad_af
        $fatal(1, "async_fifo_lvl: AF_MARGIN out of range");
    end
    if (AE_MARGIN < 0 || AE_MARGIN > DEPTH - 1) begin : g_bad_ae
        $fatal(1, "async_fifo_lvl: AE_MARGIN out of range");
    end

    logic [DW-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr, wr_gray, wr_ptr_next;
    logic [PW-1:0] rd_ptr, rd_gray, rd_ptr_next;
    logic [PW-1:0] rd_gray_sync, wr_gray_sync;
    logic [PW-1:0] rd_ptr_sync_bin, wr_ptr_sync_bin;
    logic          wr_accept, rd_accept;

    // Write domain
    assign rd_ptr_sync_bin = PW'(gray2bin(32'(rd_gray_sync), PW));
    assign wrCount         = wr_ptr - rd_ptr_sync_bin;
    assign full            = (wrCount == PW'(DEPTH));
    assign almostFull      = (wrCount >= PW'(DEPTH - AF_MARGIN));
    assign wr_accept       = wrEn && !full;
    assign wr_ptr_next     = wr_ptr + 1'b1;

    // Gray copy updates on the same edge as the binary pointer so it never lags the crossing.
    always_ff @(posedge wrClk or negedge wrRst_n) begin
        if (!wrRst_n) begin
            wr_ptr   <= '0;
            wr_gray  <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr  <= wr_ptr_next;
                wr_gray <= PW'(bin2gray(32'(wr_ptr_next), PW));
            end
            if (wrEn && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge wrClk) begin
        if (wr_accept) begin
            mem[wr_ptr[AW-1:0]] <= wrData;
        end
    end

    cdc_sync_bus #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_rd2wr (
        .clk   (wrClk),
        .rst_n (wrRst_n),
        .d     (rd_gray),
        .q     (rd_gray_sync)
    );

    // Read domain
    assign wr_ptr_sync_bin = PW'(gray2bin(32'(wr_gray_sync), PW));
    assign rdCount         = wr_ptr_sync_bin - rd_ptr;
    assign empty           = (rdCount == '0);
    assign almostEmpty     = (rdCount <= PW'(AE_MARGIN));
    assign rd_accept       = rdEn && !empty;
    assign rd_ptr_next     = rd_ptr + 1'b1;

    always_ff @(posedge rdClk or negedge rdRst_n) begin
        if (!rdRst_n) begin
            rd_ptr    <= '0;
            rd_gray   <= '0;
            rdData    <= '0;
            rdValid   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rdValid <= rd_accept;
            if (rd_accept) begin
                rd_ptr  <= rd_ptr_next;
                rd_gray <= PW'(bin2gray(32'(rd_ptr_next), PW));
                rdData  <= mem[rd_ptr[AW-1:0]];
            end
            if (rdEn && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    cdc_sync_bus #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_wr2rd (
        .clk   (rdClk),
        .rst_n (rdRst_n),
        .d     (wr_gray),
        .q     (wr_gray_sync)
    );

endmodule

// File: tb/tb_async_fifo_lvl.sv
// tb/tb_async_fifo_lvl.sv - scoreboard bench for async_fifo_lvl
`timescale 1ns/1ps
module tb_async_fifo_lvl;
    localparam int N_RAND = 10000;

    logic        wrClk = 1'b0, rdClk = 1'b0;
    logic        wrRst_n = 1'b0, rdRst_n = 1'b0;
    logic        wrEn = 1'b0, rdEn = 1'b0;
    logic [31:0] wrData = '0;
    logic        full, almostFull, overflow, rdValid, empty, almostEmpty, underflow;
    logic [4:0]  wrCount, rdCount;
    logic [31:0] rdData;

    logic        wrEn2 = 1'b0, rdEn2 = 1'b0;
    logic [31:0] wrData2 = '0;
    logic        full2, almostFull2, overflow2, rdValid2, empty2, almostEmpty2, underflow2;
    logic [6:0]  wrCount2, rdCount2;
    logic [31:0] rdData2;

    real wr_half = 5.0;
    real rd_half = 7.03;
    always #(wr_half) wrClk = ~wrClk;
    always #(rd_half) rdClk = ~rdClk;

    async_fifo_lvl #(.DEPTH(16), .DW(32), .SYNC_STAGES(2), .AF_MARGIN(2), .AE_MARGIN(2)) dut (
        .wrClk(wrClk), .wrRst_n(wrRst_n), .rdClk(rdClk), .rdRst_n(rdRst_n),
        .wrEn(wrEn), .wrData(wrData), .full(full), .almostFull(almostFull),
        .wrCount(wrCount), .overflow(overflow), .rdEn(rdEn), .rdData(rdData),
        .rdValid(rdValid), .empty(empty), .almostEmpty(almostEmpty),
        .rdCount(rdCount), .underflow(underflow)
    );

    async_fifo_lvl #(.DEPTH(64), .DW(32), .SYNC_STAGES(3), .AF_MARGIN(8), .AE_MARGIN(2)) dut2 (
        .wrClk(wrClk), .wrRst_n(wrRst_n), .rdClk(rdClk), .rdRst_n(rdRst_n),
        .wrEn(wrEn2), .wrData(wrData2), .full(full2), .almostFull(almostFull2),
        .wrCount(wrCount2), .overflow(overflow2), .rdEn(rdEn2), .rdData(rdData2),
        .rdValid(rdValid2), .empty(empty2), .almostEmpty(almostEmpty2),
        .rdCount(rdCount2), .underflow(underflow2)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: exact totals of accepted writes/pops and the expected word order.
    logic [31:0] sb_q[$];
    int  wr_total = 0;
    int  rd_total = 0;
    logic exp_valid = 1'b0;

    always @(posedge wrClk or negedge wrRst_n) begin
        if (!wrRst_n) begin
            wr_total = 0;
        end else if (wrEn && !full) begin
            wr_total++;
            sb_q.push_back(wrData);
        end
    end

    always @(posedge rdClk or negedge rdRst_n) begin
        if (!rdRst_n) begin
            rd_total  = 0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = rdEn && !empty;
            if (exp_valid) rd_total++;
        end
    end

    always @(negedge rdClk) begin
        if (rdRst_n && wrRst_n) begin
            chk("rd_valid", rdValid, exp_valid);
            if (rdValid) begin
                chk("sb_has_word", 64'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) chk("rd_data", rdData, sb_q.pop_front());
            end
            chk("rd_count_le_occ", 64'(int'(rdCount) <= wr_total - rd_total), 1);
        end
    end

    always @(negedge wrClk) begin
        if (rdRst_n && wrRst_n) begin
            chk("wr_count_bounds", 64'(wrCount <= 16 && int'(wrCount) >= wr_total - rd_total), 1);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        wrEn = 0; rdEn = 0; wrEn2 = 0;
        wrRst_n = 0; rdRst_n = 0;
        repeat (3) @(posedge wrClk);
        #1;
        wrRst_n = 1; rdRst_n = 1;
        repeat (2) @(posedge rdClk);
        #1;
    endtask

    initial begin
        int lat;
        int c;
        int target;

        do_reset();
        chk("rst_empty", empty, 1);
        chk("rst_almost_empty", almostEmpty, 1);
        chk("rst_full", full, 0);
        chk("rst_almost_full", almostFull, 0);
        chk("rst_wr_count", wrCount, 0);
        chk("rst_rd_count", rdCount, 0);
        chk("rst_rd_valid", rdValid, 0);
        chk("rst_rd_data", rdData, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_underflow", underflow, 0);

        // Fill to full and one extra write.
        for (int k = 1; k <= 17; k++) begin
            @(negedge wrClk);
            wrEn = 1; wrData = 32'(k - 1);
            @(posedge wrClk);
            #1;
            chk("fill_wr_count", wrCount, (k > 16) ? 16 : k);
            chk("fill_full", full, k >= 16);
            chk("fill_almost_full", almostFull, k >= 14);
            chk("fill_overflow", overflow, k == 17);
        end
        @(negedge wrClk);
        wrEn = 0;

        target = rd_total + 16;
        c = 0;
        while (rd_total < target && c < 300) begin
            @(negedge rdClk);
            rdEn = !empty;
            c++;
        end
        @(negedge rdClk);
        rdEn = 0;
        repeat (3) @(negedge rdClk);
        chk("drain_pops", rd_total, 16);
        chk("drain_sb_empty", sb_q.size(), 0);
        chk("drain_overflow_sticky", overflow, 1);

        // Single word and empty-release latency.
        @(negedge wrClk);
        wrEn = 1; wrData = 32'hA5A5_A5A5;
        @(posedge wrClk);
        fork begin @(negedge wrClk); wrEn = 0; end join_none
        lat = 0;
        while (empty && lat < 10) begin
            @(posedge rdClk);
            #0.5;
            lat++;
        end
        chk("empty_release_latency", 64'(lat >= 2 && lat <= 3), 1);
        @(negedge rdClk);
        rdEn = 1;
        @(posedge rdClk);
        #1;
        chk("single_rd_valid", rdValid, 1);
        chk("single_rd_data", rdData, 32'hA5A5_A5A5);
        @(negedge rdClk);
        rdEn = 0;
        repeat (6) @(negedge rdClk);

        // Read while empty.
        chk("pre_underflow", underflow, 0);
        @(negedge rdClk);
        rdEn = 1;
        @(negedge rdClk);
        rdEn = 0;
        chk("underflow_set", underflow, 1);
        chk("underflow_rd_valid", rdValid, 0);
        chk("underflow_rd_count", rdCount, 0);
        repeat (5) @(negedge rdClk);
        chk("underflow_sticky", underflow, 1);
        chk("underflow_empty", empty, 1);

        // Deeper instance with three-stage synchronisers.
        @(negedge wrClk);
        wrEn2 = 1; wrData2 = 32'h1;
        @(posedge wrClk);
        fork begin @(negedge wrClk); wrEn2 = 0; end join_none
        lat = 0;
        while (empty2 && lat < 12) begin
            @(posedge rdClk);
            #0.5;
            lat++;
        end
        chk("dut2_empty_release_latency", 64'(lat >= 3 && lat <= 4), 1);
        for (int k = 2; k <= 57; k++) begin
            @(negedge wrClk);
            wrEn2 = 1; wrData2 = 32'(k);
            @(posedge wrClk);
            #1;
            if (k >= 54) begin
                chk("dut2_wr_count", wrCount2, k);
                chk("dut2_almost_full", almostFull2, k >= 56);
            end
        end
        @(negedge wrClk);
        wrEn2 = 0;

        // Randomised traffic with a faster reader.
        rd_half = 3.333;
        do_reset();
        chk("rst2_overflow", overflow, 0);
        chk("rst2_underflow", underflow, 0);
        chk("rst2_sb_empty", sb_q.size(), 0);
        fork
            begin
                int wc = 0;
                forever begin
                    @(negedge wrClk);
                    if (wr_total >= N_RAND || wc >= 40000) break;
                    wrEn   = !full && ($urandom_range(3) != 0);
                    wrData = $urandom;
                    wc++;
                end
                wrEn = 0;
            end
            begin
                int rc = 0;
                forever begin
                    @(negedge rdClk);
                    if (rd_total >= N_RAND || rc >= 80000) break;
                    rdEn = ($urandom_range(2) != 0);
                    rc++;
                end
                rdEn = 0;
            end
        join
        repeat (4) @(negedge rdClk);
        chk("rand_writes", wr_total, N_RAND);
        chk("rand_reads", rd_total, N_RAND);
        chk("rand_sb_empty", sb_q.size(), 0);
        chk("rand_empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
